// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box, round constants and word rotation.
// Used by the key schedule blocks and the cipher cores.
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic {
        REV_IDLE = 1'b0,
        REV_RUN  = 1'b1
    } rev_state_e;

    // Row r holds S-box entries 16*r .. 16*r+15, leftmost byte first.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 is unused; rounds are numbered from 1.
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Combinational SubWord: four parallel S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign word_o[8*gi +: 8] = sbox(word_i[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_key_reverser.sv
// Inverse AES-128 key schedule: walks back from the round-10 key, one round
// key per clock, into an 11-entry key file with a registered read port.
module aes_key_reverser #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] last_key,
    input  logic [3:0]   round_num,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);
    import aes_pkg::*;

    rev_state_e   state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         done_q, done_d;
    logic         valid_q, valid_d;
    logic [127:0] round_key_q;
    logic [127:0] key_q [0:NR];

    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [127:0] wr_data;

    logic [127:0] cur_key;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot_p3, sub_p3;
    logic [127:0] prev_key;

    assign cur_key          = key_q[cnt_q];
    assign {w0, w1, w2, w3} = cur_key;

    assign p3     = w3 ^ w2;
    assign p2     = w2 ^ w1;
    assign p1     = w1 ^ w0;
    assign rot_p3 = rot_word(p3);

    aes_sub_word u_sub_word (
        .word_i (rot_p3),
        .word_o (sub_p3)
    );

    assign p0       = w0 ^ sub_p3 ^ {RCON[cnt_q], 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_idx  = 4'd0;
        wr_data = prev_key;
        case (state_q)
            REV_IDLE: begin
                if (start) begin
                    wr_en   = 1'b1;
                    wr_idx  = 4'(NR);
                    wr_data = last_key;
                    cnt_d   = 4'(NR);
                    valid_d = 1'b0;
                    state_d = REV_RUN;
                end
            end
            REV_RUN: begin
                wr_en  = 1'b1;
                wr_idx = cnt_q - 4'd1;
                cnt_d  = cnt_q - 4'd1;
                // The step that writes key[0] closes the operation.
                if (cnt_q == 4'd1) begin
                    state_d = REV_IDLE;
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: state_d = REV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REV_IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    // Key file and read register share one process; a same-cycle read sees
    // the entry's previous content.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++) begin
                key_q[i] <= '0;
            end
            round_key_q <= '0;
        end else begin
            if (wr_en) begin
                key_q[wr_idx] <= wr_data;
            end
            round_key_q <= (round_num > 4'(NR)) ? '0 : key_q[round_num];
        end
    end

    assign round_key  = round_key_q;
    assign busy       = (state_q == REV_RUN);
    assign done       = done_q;
    assign keys_valid = valid_q;

endmodule

// File: tb/tb_aes_key_reverser.sv
// Scoreboard bench for aes_key_reverser: directed FIPS-197 vectors, a forward
// key expansion model for the round trip, start/reset interactions.
module tb_aes_key_reverser;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] last_key = '0;
    logic [3:0]   round_num = '0;
    logic [127:0] round_key;
    logic         busy, done, keys_valid;

    always #5 clk = ~clk;

    aes_key_reverser #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .last_key   (last_key),
        .round_num  (round_num),
        .round_key  (round_key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    logic [127:0] a1 [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    logic [127:0] fw [0:10];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic         rd_issue = 1'b0;
    logic [127:0] rd_exp_q [$];
    int           rd_addr_q [$];
    int           done_exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: compares read data one cycle after each issued address and
    // the cycle in which every done pulse appears.
    always @(posedge clk) begin
        logic was_rd;
        was_rd = rd_issue;
        cyc++;
        #1;
        if (was_rd) begin
            if (rd_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL read: no expectation queued, got %h", round_key);
            end else begin
                check($sformatf("read r%0d", rd_addr_q.pop_front()), round_key, rd_exp_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            if (done_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL done: unexpected pulse at cycle %0d, expected none", cyc);
            end else begin
                check("done cycle", 128'(cyc), 128'(done_exp_q.pop_front()));
            end
        end
    end

    task automatic rd(input int a, input logic [127:0] e);
        @(negedge clk);
        round_num = 4'(a);
        rd_issue  = 1'b1;
        rd_exp_q.push_back(e);
        rd_addr_q.push_back(a);
    endtask

    task automatic rd_stop();
        @(negedge clk);
        rd_issue = 1'b0;
    endtask

    // Called at a negedge; start is sampled at the following edge E0.
    task automatic start_run(input logic [127:0] k);
        last_key = k;
        start    = 1'b1;
        done_exp_q.push_back(cyc + 11);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge of the done cycle, or flags a timeout.
    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) begin
            checks++; errors++;
            $display("FAIL done timeout: no pulse within %0d cycles, expected one", n);
        end
    endtask

    initial begin
        logic [31:0] w0, w1, w2, w3, t;
        fw[0] = 128'h1b7c140922ae01a64bf41b8803ba4f4a;
        for (int r = 1; r <= 10; r++) begin
            {w0, w1, w2, w3} = fw[r-1];
            t  = {w3[23:0], w3[31:24]};
            t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
            t  = t ^ {RCON[r], 24'h0};
            w0 = w0 ^ t;
            w1 = w1 ^ w0;
            w2 = w2 ^ w1;
            w3 = w3 ^ w2;
            fw[r] = {w0, w1, w2, w3};
        end

        // Reset state
        #1;
        check("reset busy", 128'(busy), 128'(0));
        check("reset done", 128'(done), 128'(0));
        check("reset keys_valid", 128'(keys_valid), 128'(0));
        check("reset round_key", round_key, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd(0, 128'h0);
        rd(10, 128'h0);
        rd_stop();

        // FIPS-197 A.1 reversal, full sweep and out-of-range addresses
        start_run(a1[10]);
        check("running busy", 128'(busy), 128'(1));
        wait_done();
        check("done keys_valid", 128'(keys_valid), 128'(1));
        check("done busy", 128'(busy), 128'(0));
        for (int r = 0; r <= 10; r++) rd(r, a1[r]);
        rd(11, 128'h0);
        rd(15, 128'h0);
        rd(10, a1[10]);
        rd_stop();

        // start during RUN is ignored
        @(negedge clk);
        start_run(a1[10]);
        repeat (2) @(negedge clk);
        last_key = 128'hdeadbeef_cafef00d_01234567_89abcdef;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        for (int r = 0; r <= 10; r++) rd(r, a1[r]);
        rd_stop();

        // back-to-back start in the done cycle, round trip with the expander
        @(negedge clk);
        start_run(a1[10]);
        wait_done();
        start_run(fw[10]);
        check("b2b keys_valid drop", 128'(keys_valid), 128'(0));
        check("b2b busy", 128'(busy), 128'(1));
        wait_done();
        rd(0, 128'h1b7c140922ae01a64bf41b8803ba4f4a);
        for (int r = 1; r <= 10; r++) rd(r, fw[r]);
        rd_stop();

        // asynchronous reset mid-run
        @(negedge clk);
        start_run(a1[10]);
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        done_exp_q.delete();
        #1;
        check("abort busy", 128'(busy), 128'(0));
        check("abort done", 128'(done), 128'(0));
        check("abort keys_valid", 128'(keys_valid), 128'(0));
        check("abort round_key", round_key, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(0, 128'h0);
        rd(5, 128'h0);
        rd(9, 128'h0);
        rd(10, 128'h0);
        rd_stop();
        @(negedge clk);
        start_run(a1[10]);
        wait_done();
        check("post-reset keys_valid", 128'(keys_valid), 128'(1));
        rd(0, a1[0]);
        rd(1, a1[1]);
        rd(9, a1[9]);
        rd(10, a1[10]);
        rd_stop();

        repeat (3) @(negedge clk);
        check("pending done", 128'(done_exp_q.size()), 128'(0));
        check("pending reads", 128'(rd_exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
